// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM note sequencer.
// Note-table entry layout is {dur, vol, n} with n at the LSBs.
package pwm_seq_pkg;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned AW_DEF    = 4;
  localparam int unsigned NW_DEF    = 10;
  localparam int unsigned VW_DEF    = 8;
  localparam int unsigned DW_DEF    = 8;

  // Field offsets inside a table entry / wr_data word
  localparam int unsigned N_LSB = 0;
  localparam int unsigned V_LSB = N_LSB + NW_DEF;
  localparam int unsigned D_LSB = V_LSB + VW_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pwm_note_sequencer_if.sv
// Control/table-write and pwm_audio-facing signals of the note sequencer.
// master = register/control side, slave = the sequencer itself.
interface pwm_note_sequencer_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned NW = 10,
  parameter int unsigned VW = 8,
  parameter int unsigned DW = 8
);
  localparam int unsigned EW = DW + VW + NW;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [EW-1:0] wr_data;
  logic          start;
  logic          stop;
  logic          loop;
  logic [NW-1:0] pwm_n;
  logic [VW-1:0] pwm_volume;
  logic          pwm_en;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_idx;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop,
    input  pwm_n, pwm_volume, pwm_en, busy, done, cur_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop,
    output pwm_n, pwm_volume, pwm_en, busy, done, cur_idx
  );

endinterface

// File: rtl/pwm_seq_table.sv
// Note table: DEPTH x EW flop array, one write port, combinational read,
// cleared by reset.
module pwm_seq_table #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned EW    = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [EW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [EW-1:0] rd_data_c
);

  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_c = mem_q[rd_addr_i];

endmodule

// File: rtl/pwm_note_sequencer.sv
// Plays a programmable note table into pwm_audio (period, volume, enable).
// Optional PWM_SEQ_FADE_EN halves the volume during each note's last period.
module pwm_note_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned NW    = NW_DEF,
  parameter int unsigned VW    = VW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  pwm_note_sequencer_if.slave    bus
);

  localparam int unsigned EW = DW + VW + NW;

  seq_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [NW-1:0] period_cnt_q, period_cnt_d;
  logic [DW-1:0] dur_cnt_q, dur_cnt_d;
  logic [NW-1:0] pwm_n_q, pwm_n_d;
  logic [VW-1:0] pwm_vol_q, pwm_vol_d;
`ifdef PWM_SEQ_FADE_EN
  logic [VW-1:0] vol_q, vol_d;
`endif
  logic          pwm_en_q, busy_q, done_q;

  logic [EW-1:0] rd_data;
  logic [NW-1:0] rd_n;
  logic [VW-1:0] rd_vol;
  logic [DW-1:0] rd_dur;
  logic [NW-1:0] eff_n;
  logic          period_end;
  logic          tbl_we;

  // Table is only writable while idle so a playing tune cannot be corrupted
  assign tbl_we = bus.wr_en && (state_q == IDLE);

  pwm_seq_table #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .EW    (EW)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (tbl_we),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_addr_i (idx_q),
    .rd_data_c (rd_data)
  );

  assign rd_n   = rd_data[N_LSB +: NW];
  assign rd_vol = rd_data[V_LSB +: VW];
  assign rd_dur = rd_data[D_LSB +: DW];

  // A zero period would never reach its terminal count; play it as period 1
  assign eff_n      = (pwm_n_q == '0) ? NW'(1) : pwm_n_q;
  assign period_end = (period_cnt_q == (eff_n - NW'(1)));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    period_cnt_d = period_cnt_q;
    dur_cnt_d    = dur_cnt_q;
    pwm_n_d      = pwm_n_q;
    pwm_vol_d    = pwm_vol_q;
`ifdef PWM_SEQ_FADE_EN
    vol_d        = vol_q;
`endif

    if (bus.stop && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_d = LOAD;
            idx_d   = '0;
          end
        end
        LOAD: begin
          if (rd_dur == '0) begin
            if (bus.loop) idx_d   = '0;
            else          state_d = DONE;
          end else begin
            pwm_n_d      = rd_n;
            dur_cnt_d    = rd_dur;
            period_cnt_d = '0;
            state_d      = PLAY;
`ifdef PWM_SEQ_FADE_EN
            vol_d        = rd_vol;
            pwm_vol_d    = (rd_dur == DW'(1)) ? (rd_vol >> 1) : rd_vol;
`else
            pwm_vol_d    = rd_vol;
`endif
          end
        end
        PLAY: begin
          if (period_end) begin
            period_cnt_d = '0;
            dur_cnt_d    = dur_cnt_q - DW'(1);
`ifdef PWM_SEQ_FADE_EN
            // Entering the final period of the note
            if (dur_cnt_q == DW'(2)) pwm_vol_d = vol_q >> 1;
`endif
            if (dur_cnt_q == DW'(1)) begin
              if (idx_q != AW'(DEPTH - 1)) begin
                idx_d   = idx_q + AW'(1);
                state_d = LOAD;
              end else if (bus.loop) begin
                idx_d   = '0;
                state_d = LOAD;
              end else begin
                state_d = DONE;
              end
            end
          end else begin
            period_cnt_d = period_cnt_q + NW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      period_cnt_q <= '0;
      dur_cnt_q    <= '0;
      pwm_n_q      <= '0;
      pwm_vol_q    <= '0;
`ifdef PWM_SEQ_FADE_EN
      vol_q        <= '0;
`endif
      pwm_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      period_cnt_q <= period_cnt_d;
      dur_cnt_q    <= dur_cnt_d;
      pwm_n_q      <= pwm_n_d;
      pwm_vol_q    <= pwm_vol_d;
`ifdef PWM_SEQ_FADE_EN
      vol_q        <= vol_d;
`endif
      pwm_en_q     <= (state_d == PLAY);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
    end
  end

  assign bus.pwm_n      = pwm_n_q;
  assign bus.pwm_volume = pwm_vol_q;
  assign bus.pwm_en     = pwm_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cur_idx    = idx_q;

endmodule

// File: doc/pwm_note_sequencer.md
Name: pwm_note_sequencer

Overview:
Sequencer that drives the pwm_audio block's N (period) and volume inputs from a small programmable note table, so the PWM plays a tune without CPU involvement. Each table entry holds a period, a volume and a duration counted in whole PWM periods. The block sits between the register/control interface and pwm_audio, and owns pwm_audio's enable.

Parameters:
DEPTH, 16, number of note-table entries (power of 2)
AW, 4, table address width, log2(DEPTH)
NW, 10, period width; matches pwm_audio N
VW, 8, volume width; matches pwm_audio volume
DW, 8, duration width, in PWM periods

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  table write strobe
wr_addr  in  AW  table write address
wr_data  in  DW+VW+NW  entry {dur, vol, n}: dur in [25:18], vol in [17:10], n in [9:0]
start  in  1  single-cycle pulse; begin playback at entry 0
stop  in  1  single-cycle pulse; abort playback
loop  in  1  level; restart at entry 0 after the last entry instead of finishing
pwm_n  out  NW  period to pwm_audio N
pwm_volume  out  VW  volume to pwm_audio volume
pwm_en  out  1  high only in PLAY; gates/holds pwm_audio
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal completion
cur_idx  out  AW  index of the entry being played

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: state IDLE; all table entries 0; pwm_n=0, pwm_volume=0, pwm_en=0, busy=0, done=0, cur_idx=0; internal period_cnt=0, dur_cnt=0.
- Table writes: accepted only in IDLE. wr_en in any other state is ignored.
- States: IDLE, LOAD, PLAY, DONE.
- IDLE:
  - start=1 and stop=0 -> LOAD, with idx=0.
  - stop=1 has priority over start (stays in IDLE).
- LOAD (one cycle): read table[idx].
  - dur==0 is the end marker -> DONE.
  - Otherwise register pwm_n=n, pwm_volume=vol, dur_cnt=dur, period_cnt=0 -> PLAY.
  - n==0 is treated as n=1.
- PLAY:
  - pwm_en=1. period_cnt increments every clk.
  - At period_cnt==eff_n-1: period_cnt wraps to 0 and dur_cnt decrements.
  - When the period end occurs with dur_cnt==1, the note ends:
    - idx<DEPTH-1: idx++ -> LOAD.
    - idx==DEPTH-1 and loop=1: idx=0 -> LOAD.
    - idx==DEPTH-1 and loop=0: -> DONE.
- An end marker reached while loop=1 also returns to idx=0 -> LOAD. A table whose entry 0 has dur==0 with loop=1 therefore cycles LOAD forever, with pwm_en low and busy high; this is intended.
- DONE: done=1 for exactly one cycle -> IDLE. pwm_n and pwm_volume hold their last values; pwm_en=0.
- stop in LOAD, PLAY or DONE: -> IDLE on the next edge. pwm_en drops on that edge and no done pulse is produced.
- start while busy is ignored.
- Latency:
  - start sampled at edge k: busy=1 after k; pwm_en=1 after k+1.
  - A note with n=N and dur=D occupies exactly N*D PLAY cycles, followed by one LOAD cycle with pwm_en=0.
- Counter widths: period_cnt is NW bits; dur_cnt is DW bits. Neither wraps beyond its terminal value.
- cur_idx mirrors idx at all times.
- Asynchronous reset mid-playback returns everything to reset values immediately, including clearing the table.

Optional Feature:
PWM_SEQ_FADE_EN:
- Defined: during the final PWM period of each note (dur_cnt==1), pwm_volume outputs vol>>1 as articulation. It returns to full vol on the next LOAD.
- Undefined: pwm_volume stays at vol for the whole note.

Decomposition:
- Package pwm_seq_pkg:
  - state enum {IDLE, LOAD, PLAY, DONE}
  - field offsets/widths for wr_data (N_LSB=0, V_LSB=10, D_LSB=18)
  - default NW/VW/DW constants
- One natural sub-module, pwm_seq_table: DEPTH x (DW+VW+NW) flop array with write port and combinational read, reset-cleared.
- The FSM and counters stay in the top level.

Test Plan:
- Write entry0={dur=2, vol=7, n=40}, entry1=0; pulse start -> busy after 1 clk; pwm_en high for exactly 80 clks with pwm_n=40, pwm_volume=7; then LOAD; then done pulse 1 clk; then IDLE, busy=0.
- Three entries (n=10,d=1), (n=20,d=2), (n=5,d=3), entry3 end -> cur_idx steps 0,1,2; PLAY lengths 10, 40, 15; single done.
- loop=1, entries (n=4,d=1), end marker -> pwm_en pattern 4 high, 1 low (LOAD), 1 low (LOAD of end marker), repeating; no done; stop -> IDLE next edge, no done.
- stop and start asserted in the same cycle in IDLE -> stays IDLE. wr_en to entry 0 during PLAY -> table unchanged, verified on the next play.
- rst_n asserted at clk 50 of a play -> all outputs 0 immediately. Start after release with no writes -> entry 0 reads dur=0 -> done after 2 clks.
- Build with PWM_SEQ_FADE_EN, entry {n=8, d=2, vol=100} -> pwm_volume=100 for 8 clks, then 50 for 8 clks.
